// File: rtl/alu_pkg.sv
// Shared opcode encoding and response layout for the ALU command engine.
package alu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned RSP_W = 8;

  typedef enum logic [OP_W-1:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    AND_ = 3'b010,
    OR_  = 3'b011,
    XOR_ = 3'b100
  } alu_op_e;

  // Response template at the default width; wider engines build the same layout locally.
  typedef struct packed {
    logic [RSP_W-1:0] y;
    logic             z;
    logic             c;
    logic             v;
    logic             err;
  } alu_rsp_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= XOR_;
  endfunction

endpackage

// File: rtl/alu_flag_core.sv
// Combinational ALU with result flags; sits between the command and response stages.
module alu_flag_core
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]    a_i,
  input  logic [N-1:0]    b_i,
  input  logic [OP_W-1:0] op_i,
  output logic [N-1:0]    y_o,
  output logic            z_o,
  output logic            c_o,
  output logic            v_o,
  output logic            err_o
);

  logic [N:0] sum;
  logic [N:0] dif;

  assign sum = {1'b0, a_i} + {1'b0, b_i};
  // A + ~B + 1: bit N is the no-borrow carry, so borrow is its inverse.
  assign dif = {1'b0, a_i} + {1'b0, ~b_i} + {{N{1'b0}}, 1'b1};

  always_comb begin
    y_o   = '0;
    c_o   = 1'b0;
    v_o   = 1'b0;
    err_o = !op_legal(op_i);
    case (op_i)
      ADD: begin
        y_o = sum[N-1:0];
        c_o = sum[N];
        v_o = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      SUB: begin
        y_o = dif[N-1:0];
        c_o = ~dif[N];
        v_o = (a_i[N-1] != b_i[N-1]) && (dif[N-1] != a_i[N-1]);
      end
      AND_:    y_o = a_i & b_i;
      OR_:     y_o = a_i | b_i;
      XOR_:    y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
    z_o = (y_o == '0);
  end

endmodule

// File: rtl/alu_cmd_engine.sv
// Two-stage valid/ready ALU command engine with saturating hand-off counters.
module alu_cmd_engine
  import alu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [OP_W-1:0]  ALU_SEL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     Y,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             ERR,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic [N-1:0] y;
    logic         z;
    logic         c;
    logic         v;
    logic         err;
  } rsp_t;

  logic             run_q;
  logic             s1_v_q, s1_v_d;
  logic [N-1:0]     s1_a_q, s1_b_q;
  logic [OP_W-1:0]  s1_op_q;
  logic             s2_v_q, s2_v_d;
  rsp_t             s2_q, s2_d;
  logic [CNT_W-1:0] done_q, done_d, err_q, err_d;

  logic [N-1:0]     core_y;
  logic             core_z, core_c, core_v, core_err;
  logic             s1_adv, s2_adv, in_fire, out_fire;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  // run_q keeps in_ready low during reset without a combinational path from rst_n.
  assign in_ready = run_q && s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_v_q && out_ready;

  alu_flag_core #(
    .N (N)
  ) u_core (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .op_i  (s1_op_q),
    .y_o   (core_y),
    .z_o   (core_z),
    .c_o   (core_c),
    .v_o   (core_v),
    .err_o (core_err)
  );

  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    s2_d   = s2_q;
    done_d = done_q;
    err_d  = err_q;
    if (s1_adv) begin
      s1_v_d = in_fire;
    end
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_d = '{y: core_y, z: core_z, c: core_c, v: core_v, err: core_err};
      end
    end
    if (clr_cnt) begin
      done_d = '0;
      err_d  = '0;
    end else if (out_fire) begin
      if (done_q != '1) done_d = done_q + CNT_W'(1);
      if (s2_q.err && (err_q != '1)) err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_op_q <= '0;
      s2_v_q  <= 1'b0;
      s2_q    <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      run_q  <= 1'b1;
      s1_v_q <= s1_v_d;
      if (in_fire) begin
        s1_a_q  <= A;
        s1_b_q  <= B;
        s1_op_q <= ALU_SEL;
      end
      s2_v_q <= s2_v_d;
      s2_q   <= s2_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign out_valid = s2_v_q;
  assign Y         = s2_q.y;
  assign Z         = s2_q.z;
  assign C         = s2_q.c;
  assign V         = s2_q.v;
  assign ERR       = s2_q.err;
  assign done_cnt  = done_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Self-checking bench for alu_cmd_engine: directed vector table, stall/reset sequences, random stream.
module tb_alu_cmd_engine;

  localparam int N     = 8;
  localparam int CNT_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       c;
    logic       v;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    rsp_t       exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     A = '0;
  logic [N-1:0]     B = '0;
  logic [2:0]       ALU_SEL = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     Y;
  logic             Z, C, V, ERR;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] done_cnt, err_cnt;

  always #5 clk = ~clk;

  alu_cmd_engine #(
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_SEL   (ALU_SEL),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .Z         (Z),
    .C         (C),
    .V         (V),
    .ERR       (ERR),
    .clr_cnt   (clr_cnt),
    .done_cnt  (done_cnt),
    .err_cnt   (err_cnt)
  );

  int   errors = 0;
  int   checks = 0;
  rsp_t exp_q[$];
  int   exp_done = 0;
  int   exp_err = 0;
  int   rsp_cnt = 0;
  bit   stall_prev = 0;
  rsp_t held;
  bit   last_ov, last_in_ready, last_hs_in, last_hs_out;
  rsp_t last_rsp;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour from the opcode rules, using plain integer arithmetic.
  function automatic rsp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    rsp_t m;
    int ua, ub, sa, sb, r, s;
    m  = '0;
    ua = int'(a);
    ub = int'(b);
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: begin
        r = ua + ub; s = sa + sb;
        m.y = r[7:0]; m.c = (r > 255); m.v = (s > 127) || (s < -128);
      end
      3'd1: begin
        r = ua - ub; s = sa - sb;
        m.y = r[7:0]; m.c = (ua < ub); m.v = (s > 127) || (s < -128);
      end
      3'd2: m.y = a & b;
      3'd3: m.y = a | b;
      3'd4: m.y = a ^ b;
      default: m.err = 1'b1;
    endcase
    m.z = (m.y == 8'h00);
    return m;
  endfunction

  function automatic int sat_inc(input int v, input bit inc);
    if (inc && v < CMAX) return v + 1;
    return v;
  endfunction

  // One cycle: inputs already driven after a negedge; sample, score, then wait for next negedge.
  task automatic tick();
    rsp_t got, e;
    bit   err_inc;
    #1;
    got.y = Y; got.z = Z; got.c = C; got.v = V; got.err = ERR;
    chk("done_cnt", done_cnt, exp_done);
    chk("err_cnt", err_cnt, exp_err);
    if (stall_prev) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", got, held);
    end
    last_ov       = out_valid;
    last_in_ready = in_ready;
    last_hs_in    = in_valid && in_ready;
    last_hs_out   = out_valid && out_ready;
    last_rsp      = got;
    err_inc       = 1'b0;
    if (last_hs_out) begin
      chk("rsp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_order", got, e);
        err_inc = e.err;
      end
      rsp_cnt++;
    end
    if (last_hs_in) exp_q.push_back(model(ALU_SEL, A, B));
    stall_prev = out_valid && !out_ready;
    held       = got;
    exp_done   = clr_cnt ? 0 : sat_inc(exp_done, last_hs_out);
    exp_err    = clr_cnt ? 0 : sat_inc(exp_err, err_inc);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] bp_op[4];
    logic [7:0] bp_a[4], bp_b[4];
    int k, base, sent, prev_c;
    bit need;

    vecs[0]  = '{3'd0, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[1]  = '{3'd0, 8'h80, 8'h80, '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[2]  = '{3'd1, 8'h00, 8'hFF, '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{3'd1, 8'h7F, 8'hFF, '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[4]  = '{3'd6, 8'h12, 8'h34, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[5]  = '{3'd2, 8'hF0, 8'h3C, '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{3'd3, 8'hF0, 8'h0C, '{8'hFC, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{3'd4, 8'hAA, 8'hAA, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{3'd0, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[9]  = '{3'd1, 8'h05, 8'h03, '{8'h02, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{3'd5, 8'hFF, 8'hFF, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[11] = '{3'd7, 8'h00, 8'h00, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[12] = '{3'd1, 8'h80, 8'h01, '{8'h7F, 1'b0, 1'b0, 1'b1, 1'b0}};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outputs", {Y, Z, C, V, ERR}, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("in_ready_after_rst", last_in_ready, 1);

    // Directed vectors: single command, unstalled, latency and flags
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      ALU_SEL = vecs[i].op; A = vecs[i].a; B = vecs[i].b; in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_accept", i), last_hs_in, 1);
      in_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_lat1", i), last_ov, 0);
      tick();
      chk($sformatf("vec%0d_lat2", i), last_ov, 1);
      chk($sformatf("vec%0d_rsp", i), last_rsp, vecs[i].exp);
    end
    tick();

    // Backpressure: four back-to-back commands against a stalled consumer
    for (int i = 0; i < 4; i++) begin
      bp_op[i] = 3'($urandom_range(0, 4)); bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom);
    end
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; ALU_SEL = bp_op[k]; A = bp_a[k]; B = bp_b[k];
      tick();
      if (last_hs_in) k++;
    end
    chk("bp_accepted", k, 2);
    chk("bp_in_ready_low", last_in_ready, 0);
    // Release, clearing counters on the first hand-off cycle
    out_ready = 1'b1;
    clr_cnt = 1'b1;
    base = rsp_cnt;
    prev_c = -1;
    for (int c = 0; c < 20 && (rsp_cnt - base) < 4; c++) begin
      in_valid = (k < 4);
      if (k < 4) begin ALU_SEL = bp_op[k]; A = bp_a[k]; B = bp_b[k]; end
      tick();
      clr_cnt = 1'b0;
      if (last_hs_in) k++;
      if (last_hs_out) begin
        if (prev_c >= 0) chk("bp_gap", (c - prev_c) <= 2, 1);
        prev_c = c;
      end
    end
    in_valid = 1'b0;
    chk("bp_rsps", rsp_cnt - base, 4);
    tick();

    // Streaming: 20 random legal commands, consumer always ready
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    base = rsp_cnt; sent = 0; need = 1'b1;
    for (int c = 0; c < 200 && (rsp_cnt - base) < 20; c++) begin
      if (sent < 20) begin
        if (need) begin
          ALU_SEL = 3'($urandom_range(0, 4)); A = 8'($urandom); B = 8'($urandom); need = 1'b0;
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (last_hs_in) begin sent++; need = 1'b1; end
    end
    in_valid = 1'b0;
    chk("stream_rsps", rsp_cnt - base, 20);
    chk("stream_done_cnt", done_cnt, 20);

    // Random valid/ready with illegal ops; pushes done_cnt into saturation
    base = rsp_cnt; sent = 0; need = 1'b1;
    for (int c = 0; c < 400 && (rsp_cnt - base) < 15; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 15 && $urandom_range(0, 3) != 0) begin
        if (need) begin
          ALU_SEL = 3'($urandom); A = 8'($urandom); B = 8'($urandom); need = 1'b0;
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (last_hs_in) begin sent++; need = 1'b1; end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_rsps", rsp_cnt - base, 15);
    tick();
    chk("sat_done_cnt", done_cnt, CMAX);

    // Reset with both stages full
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10 && k < 2; c++) begin
      in_valid = 1'b1; ALU_SEL = 3'd0; A = 8'(c); B = 8'h11;
      tick();
      if (last_hs_in) k++;
    end
    in_valid = 1'b0;
    chk("rst_fill", k, 2);
    chk("rst_fill_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_done_cnt", done_cnt, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    exp_q.delete();
    exp_done = 0; exp_err = 0; stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_rst_idle", last_ov, 0);
    end
    base = rsp_cnt;
    ALU_SEL = 3'd4; A = 8'h5A; B = 8'h0F; in_valid = 1'b1;
    for (int c = 0; c < 10 && (rsp_cnt - base) < 1; c++) begin
      tick();
      if (last_hs_in) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("post_rst_rsp", rsp_cnt - base, 1);
    chk("post_rst_y", last_rsp.y, 8'h55);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
